// File: rtl/uart_host_scheduler.sv
// uart_host_scheduler
//
// Purpose: sits between NUM_REQ on-chip byte producers, one byte consumer and
// a FIFO-backed UART. It round-robin arbitrates whole TX bursts onto the UART
// write port, drains the UART RX FIFO into a one-entry output register and
// owns the baud divisor. Divisor changes are applied only between bursts.
//
// Optional build macro: UART_SCHED_TIMEOUT_EN
//   When defined, a burst whose owner stalls (no transfer, TX FIFO not full)
//   for TIMEOUT_CYCLES cycles is force-terminated. A one-cycle burst_timeout
//   pulse is added to the ports.
//
// Handshakes (valid/ready): a byte moves on a cycle where valid and ready are
// both high at the rising clock edge. req_ready and read_uart are
// combinational. rx_valid/rx_byte are registered and hold steady while
// rx_valid is high and rx_ready is low.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_data/req_last/req_ready   per-requester TX byte interface
//   grant, busy         one-hot burst owner (0 when idle), burst active flag
//   cfg_wr, cfg_divisor divisor write strobe and value
//   final_value         divisor driven to the UART
//   cfg_pending         divisor write waiting for an idle cycle
//   write_uart, w_data, tx_full      UART TX FIFO push side
//   read_uart, r_data, rx_empty      UART RX FIFO pop side (fall-through head)
//   rx_valid, rx_byte, rx_ready      received-byte output stage
//   burst_timeout       (macro only) one-cycle forced-termination pulse
//   o_dbg_state         TX FSM state, 0 = IDLE, 1 = BURST
module uart_host_scheduler #(
  parameter int NUM_REQ         = 4,
  parameter int DataBits        = 8,
  parameter int DivWidth        = 11,
  parameter int DEFAULT_DIVISOR = 650,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DataBits-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  input  logic                         cfg_wr,
  input  logic [DivWidth-1:0]          cfg_divisor,
  output logic [DivWidth-1:0]          final_value,
  output logic                         cfg_pending,
  output logic                         write_uart,
  output logic [DataBits-1:0]          w_data,
  input  logic                         tx_full,
  output logic                         read_uart,
  input  logic [DataBits-1:0]          r_data,
  input  logic                         rx_empty,
  output logic                         rx_valid,
  output logic [DataBits-1:0]          rx_byte,
  input  logic                         rx_ready,
`ifdef UART_SCHED_TIMEOUT_EN
  output logic                         burst_timeout,
`endif
  output logic                         o_dbg_state
);

  localparam int PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PtrW-1:0]     LastPtr = PtrW'(NUM_REQ - 1);
  localparam logic [DivWidth-1:0] DefDiv  = DivWidth'(DEFAULT_DIVISOR);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_grant;
  logic                  r_busy;
  logic [PtrW-1:0]       r_owner;
  logic [PtrW-1:0]       r_rr_ptr;
  logic [DivWidth-1:0]   r_final_value;
  logic [DivWidth-1:0]   r_pending_val;
  logic                  r_cfg_pending;
  logic                  r_rx_valid;
  logic [DataBits-1:0]   r_rx_byte;

  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic                  w_xfer;
  logic                  w_found;
  logic [PtrW-1:0]       w_sel;
  logic                  w_cfg_direct;
  logic                  w_pop;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0]       r_stall_cnt;
  logic                  r_burst_timeout;
`endif

  // Current owner's request lines and data.
  always_comb begin
    w_owner_valid = 1'b0;
    w_owner_last  = 1'b0;
    w_data        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == PtrW'(i)) begin
        w_owner_valid = req_valid[i];
        w_owner_last  = req_last[i];
        w_data        = req_data[i*DataBits +: DataBits];
      end
    end
  end

  // Round-robin search: first valid requester strictly above rr_ptr, then
  // wrap around and take the first valid one from index 0.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (i > int'(r_rr_ptr))) begin
        w_found = 1'b1;
        w_sel   = PtrW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found = 1'b1;
        w_sel   = PtrW'(i);
      end
    end
  end

  assign w_xfer       = (r_state == S_BURST) && w_owner_valid && !tx_full && !reset;
  // A divisor write takes effect directly only when no burst can start now.
  assign w_cfg_direct = (r_state == S_IDLE) && !r_cfg_pending && !(|req_valid);
  assign w_pop        = !reset && !rx_empty && (!r_rx_valid || rx_ready);

  assign req_ready   = ((r_state == S_BURST) && !tx_full && !reset) ? r_grant : '0;
  assign write_uart  = w_xfer;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign final_value = r_final_value;
  assign cfg_pending = r_cfg_pending;
  assign read_uart   = w_pop;
  assign rx_valid    = r_rx_valid;
  assign rx_byte     = r_rx_byte;
  assign o_dbg_state = r_state;
`ifdef UART_SCHED_TIMEOUT_EN
  assign burst_timeout = r_burst_timeout;
`endif

  // TX arbitration FSM and divisor ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_busy        <= 1'b0;
      r_owner       <= '0;
      r_rr_ptr      <= LastPtr;
      r_final_value <= DefDiv;
      r_pending_val <= '0;
      r_cfg_pending <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      r_stall_cnt     <= '0;
      r_burst_timeout <= 1'b0;
`endif
    end else begin
`ifdef UART_SCHED_TIMEOUT_EN
      r_burst_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
`ifdef UART_SCHED_TIMEOUT_EN
          r_stall_cnt <= '0;
`endif
          // Pending divisor lands before the next burst is granted.
          if (r_cfg_pending) begin
            r_final_value <= r_pending_val;
            r_cfg_pending <= 1'b0;
          end
          if (w_found) begin
            r_owner <= w_sel;
            r_grant <= NUM_REQ'(1) << w_sel;
            r_busy  <= 1'b1;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_xfer && w_owner_last) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= r_owner;
          end
`ifdef UART_SCHED_TIMEOUT_EN
          // Only owner-side stalls count; a full TX FIFO holds the count.
          if (w_xfer) begin
            r_stall_cnt <= '0;
          end else if (!tx_full) begin
            if (r_stall_cnt == CntLast) begin
              r_state         <= S_IDLE;
              r_grant         <= '0;
              r_busy          <= 1'b0;
              r_rr_ptr        <= r_owner;
              r_stall_cnt     <= '0;
              r_burst_timeout <= 1'b1;
            end else begin
              r_stall_cnt <= r_stall_cnt + 1'b1;
            end
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase

      // Later write wins over a pending value applied in this same cycle.
      if (cfg_wr) begin
        if (w_cfg_direct) begin
          r_final_value <= cfg_divisor;
        end else begin
          r_pending_val <= cfg_divisor;
          r_cfg_pending <= 1'b1;
        end
      end
    end
  end

  // RX drain into a one-entry output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_rx_byte  <= '0;
    end else if (w_pop) begin
      r_rx_valid <= 1'b1;
      r_rx_byte  <= r_data;
    end else if (rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

endmodule

// File: doc/uart_host_scheduler.md
Name: uart_host_scheduler

Overview:
- Sits between several on-chip byte producers/consumers and the UART top (FIFO-backed TX/RX, divisor input Final_Value).
- Round-robin arbitrates TX bursts from NUM_REQ requesters onto the UART write port, honouring tx_full.
- Drains the RX FIFO into a one-entry valid/ready output stage.
- Owns the baud divisor and applies divisor changes only between TX bursts.

Parameters:
- NUM_REQ, 4, number of TX requesters (2..8)
- DataBits, 8, UART byte width
- DivWidth, 11, width of baud divisor
- DEFAULT_DIVISOR, 650, divisor driven after reset
- TIMEOUT_CYCLES, 1024, stall limit for optional burst timeout

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DataBits  per-requester byte; requester i occupies bits [i*DataBits +: DataBits]
- req_last  in  NUM_REQ  marks final byte of a burst
- req_ready  out  NUM_REQ  per-requester accept
- grant  out  NUM_REQ  one-hot current burst owner; 0 when idle
- busy  out  1  high while a burst is owned
- cfg_wr  in  1  divisor write strobe
- cfg_divisor  in  DivWidth  new divisor value
- final_value  out  DivWidth  divisor to UART Final_Value
- cfg_pending  out  1  divisor write waiting for idle
- write_uart  out  1  UART TX FIFO push
- w_data  out  DataBits  UART TX byte
- tx_full  in  1  UART TX FIFO full
- read_uart  out  1  UART RX FIFO pop
- r_data  in  DataBits  UART RX FIFO head (first-word-fall-through)
- rx_empty  in  1  UART RX FIFO empty
- rx_valid  out  1  received byte available
- rx_byte  out  DataBits  received byte
- rx_ready  in  1  consumer accepts rx_byte

Behaviour:
- Reset values (asynchronous): grant=0, busy=0, rr_ptr=NUM_REQ-1, final_value=DEFAULT_DIVISOR, cfg_pending=0, rx_valid=0, rx_byte=0. write_uart, read_uart and req_ready are low during reset.
- TX FSM states: IDLE, BURST.
- IDLE:
  - No byte transfers; req_ready=0.
  - If cfg_pending, final_value <= pending value and cfg_pending <= 0 this cycle.
  - If any req_valid, select the first set requester searching from rr_ptr+1 upward, wrapping at NUM_REQ. grant <= onehot(sel), busy <= 1, go to BURST.
  - Arbitration costs exactly one IDLE cycle between bursts.
- BURST (owner g):
  - req_ready[g] = !tx_full. Other req_ready bits are 0.
  - write_uart = req_valid[g] & !tx_full, combinational, zero latency. w_data = req_data[g].
  - When a byte transfers with req_last[g]=1: next state IDLE, grant<=0, busy<=0, rr_ptr<=g.
  - Without last, ownership is held indefinitely; the owner may drop req_valid between bytes.
  - tx_full high stalls the transfer. No byte is dropped or duplicated.
- Divisor configuration:
  - cfg_wr in IDLE with no pending write and no req_valid: final_value <= cfg_divisor next cycle.
  - Otherwise the value is captured into a pending register and cfg_pending <= 1; it is applied at the next IDLE cycle, before arbitration.
  - A second cfg_wr while pending overwrites the pending value (last write wins).
  - A divisor never changes mid-burst.
- RX drain:
  - pop = !rx_empty & (!rx_valid | rx_ready). read_uart = pop, combinational.
  - On pop: rx_byte <= r_data, rx_valid <= 1.
  - Else if rx_ready: rx_valid <= 0.
  - Sustains one byte per cycle. rx_byte is stable while rx_valid & !rx_ready.
- Reset asserted mid-burst: returns immediately to IDLE with reset values. A pending divisor is discarded.

Optional Feature:
- Macro UART_SCHED_TIMEOUT_EN.
- Defined:
  - A counter increments each BURST cycle with no transfer and clears on every transfer.
  - On reaching TIMEOUT_CYCLES-1 the burst is force-terminated: go to IDLE, rr_ptr<=g, and a one-cycle output pulse burst_timeout (extra 1-bit port) is asserted.
  - A stall caused by tx_full does not count.
- Undefined: no counter, no burst_timeout port; ownership lasts until req_last.

Test Plan:
- Single burst: req0 sends 0xE3, 0x93 (last on 0x93) with tx_full=0 -> grant=0001 one cycle after valid; write_uart high 2 consecutive cycles with w_data 0xE3 then 0x93; busy falls after the last byte.
- Round robin: req0..req3 all valid with 1-byte bursts -> grant order 0,1,2,3,0 with one IDLE cycle between bursts.
- Backpressure: tx_full=1 for 5 cycles mid-burst -> write_uart=0 and req_ready=0 for those cycles; byte order is intact afterwards and no duplicates.
- Divisor: cfg_wr=325 during req1's 4-byte burst -> cfg_pending=1 and final_value stays 650 until the first IDLE cycle after the last byte, then becomes 325. A further cfg_wr=163 while pending -> 163 is applied instead.
- RX drain: UART RX FIFO holds 0xAB, 0x52 and rx_ready=0 -> one pop, rx_byte=0xAB held stable. Raise rx_ready -> 0x52 follows the next cycle, then read_uart stays low once rx_empty rises.
- Reset mid-burst (and, with UART_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, owner stalls 16 cycles) -> grant=0 and busy=0; the timeout case also shows a single burst_timeout pulse and the next requester is granted.
